multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Control unit for the multicycle version of the ARM-subset DataPath.
- Consumes the fetched instruction (IR output) and the ALU flags. Drives every datapath select and write enable from a Moore FSM.
- Holds the architectural NZCV register and evaluates condition codes.
- Replaces the bench-driven control inputs of DataPath.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset (bit3=N … bit0=V).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- Instr  in  32  IR contents; stable from DECODE until the next FETCH
- N, Z, C, V  in  1 each  combinational ALU flags
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  IR enable
- RegWrite  out  1  register file write
- ResultSrc  out  2  result mux: 00 ALUOut, 01 Data reg, 10 ALU direct
- ALUSrcA  out  1  0 reg A, 1 PC
- ALUSrcB  out  2  00 reg B, 01 ExtImm, 10 constant 4
- ALUControl  out  2  00 add, 01 sub, 10 and, 11 orr
- ImmSrc  out  2  00 imm8, 01 imm12, 10 imm24<<2
- RegSrc  out  2  [0]=1 first read R15; [1]=1 second read Rd
- Undef  out  1  high during DECODE of an unsupported or illegal instruction
- Flags  out  4  current NZCV register

Behaviour:
- Decode fields:
  - op = Instr[27:26]: 00 DP, 01 MEM, 10 BR; 11 is undefined.
  - DP: I=[25], cmd=[24:21], S=[20]. Supported cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - MEM: I=[25] must be 0; U=[23] (1 add, 0 sub); L=[20] (1 LDR, 0 STR).
  - BR: [25:24] must be 10; BL is undefined.
  - cond=[31:28]: all 15 ARM conditions evaluated on the Flags register; 1111 is undefined.
- ImmSrc and RegSrc are combinational from Instr in every state:
  - ImmSrc: 00 DP, 01 MEM, 10 BR.
  - RegSrc: 01 BR, 10 STR, 00 otherwise.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- Outputs not listed for a state are 0.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1. Next state DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (PC+8 for R15).
    - Undefined → Undef=1, next FETCH.
    - Cond false → next FETCH.
    - Otherwise MEM → MEMADR; DP with I=0 → EXECR; DP with I=1 → EXECI; BR → BRANCH.
  - MEMADR: ALUSrcB=01, ALUControl = U ? 00 : 01. Next MEMREAD if L=1, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Next MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Next FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1. Next FETCH.
  - EXECR / EXECI: ALUSrcB = 00 / 01, ALUControl from cmd. Next ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Next FETCH.
  - BRANCH: ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=1. Next FETCH.
- Flags:
  - Written at the rising edge that ends EXECR/EXECI when S=1.
  - N,Z are updated for all commands.
  - C,V are updated only for ADD and SUB; they hold for AND and ORR.
  - A flag write in EXECR/EXECI does not affect outputs of the same instruction.
- Latency (cycles, FETCH included):
  - DP: 4
  - LDR: 5
  - STR: 4
  - B taken: 3
  - cond-false or undefined: 2
- Reset:
  - reset_n low → state FETCH and Flags=RESET_FLAGS, asynchronously.
  - While reset_n is low, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0. Other outputs take their FETCH values.
  - The first rising edge after release is a normal FETCH.
  - Reset mid-instruction abandons that instruction; no partial write occurs after assertion.

Optional Feature:
- Macro: CMP_TST_EN.
- Defined: cmd 1010 (CMP, ALUControl=01) and cmd 1000 (TST, ALUControl=10) with S=1 are supported. They execute EXECR/EXECI, update flags (TST updates N,Z only), then go directly to FETCH with no ALUWB and no RegWrite. Latency 3.
- Undefined: these encodings raise Undef in DECODE.
- S=0 with cmd 1010/1000 is always undefined.

Test Plan:
- ADD R1,R2,R3 (0xE0821003) after reset → states FETCH, DECODE, EXECR, ALUWB; ALUControl=00 and ALUSrcB=00 in EXECR; RegWrite=1 only in ALUWB; Flags unchanged; back in FETCH at cycle 5.
- LDR R0,[R1,#4] (0xE5910004) → MEMADR with ALUSrcB=01, ImmSrc=01, ALUControl=00; MEMREAD with AdrSrc=1; MEMWB with ResultSrc=01, RegWrite=1. Then STR R0,[R1,#-8] (0xE5010008) → ALUControl=01 and RegSrc=10; MemWrite=1 for exactly one cycle; RegWrite never asserted.
- SUBS R0,R0,#1 (0xE2500001) with ALU Z=1, N=0, C=1, V=0 → Flags=0110 after EXECI. Then BEQ (0x0A000002) → BRANCH with PCWrite=1, ImmSrc=10, RegSrc=01. Then BNE (0x1A000002) → DECODE→FETCH with no PCWrite outside FETCH.
- ANDS R0,R0,R0 (0xE0100000) with ALU N=1, Z=0, C=0, V=1 from Flags=0110 → Flags=1010 (C,V hold).
- Undefined 0xE6000000, then 0xF0821003 → Undef=1 in each DECODE; no RegWrite, MemWrite or PCWrite outside FETCH; 2 cycles each.
- reset_n low mid-MEMREAD → immediate FETCH, all write enables 0 while low, Flags=RESET_FLAGS; after release, first edge has IRWrite=1 and PCWrite=1.
- With CMP_TST_EN: CMP R0,#5 (0xE3500005) with ALU Z=1 → Flags Z=1 and no ALUWB state. Without the macro → Undef=1.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Purpose : control FSM + NZCV register for the multicycle ARM-subset datapath.
// Latency : DP 4, LDR 5, STR 4, B taken 3, cond-false/undefined 2 cycles (FETCH included).
// Backpr. : none; one instruction in flight, datapath enables are driven every cycle.
//
// Ports:
//   clock, reset_n          rising-edge clock, async active-low reset
//   Instr                   IR contents (stable from DECODE to next FETCH)
//   N, Z, C, V              combinational ALU flags
//   PCWrite..RegSrc         datapath selects / enables (Moore, except ImmSrc/RegSrc
//                           which follow Instr in every state)
//   Undef                   high in DECODE for unsupported/illegal encodings
//   Flags                   architectural NZCV register
// Optional feature: define CMP_TST_EN to support CMP (cmd 1010) and TST (cmd 1000)
// with S=1; without it those encodings decode as undefined.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] Instr,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic        Undef,
    output logic [3:0]  Flags
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;

    // Instruction fields
    logic [3:0] cond;
    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, s_bit, u_bit, l_bit;
    logic       unused_bits;

    assign cond  = Instr[31:28];
    assign op    = Instr[27:26];
    assign i_bit = Instr[25];
    assign cmd   = Instr[24:21];
    assign u_bit = Instr[23];
    assign s_bit = Instr[20];
    assign l_bit = Instr[20];
    assign unused_bits = ^Instr[19:0];

    // flag_only: compare-type DP op that updates flags but writes no register.
    logic flag_only;
`ifdef CMP_TST_EN
    assign flag_only = s_bit && (cmd == 4'b1010 || cmd == 4'b1000);
`else
    assign flag_only = 1'b0;
`endif

    logic dp_ok, instr_undef, cond_ok;

    always_comb begin
        dp_ok = (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
                (cmd == 4'b1100) || flag_only;
        case (op)
            2'b00:   instr_undef = !dp_ok;
            2'b01:   instr_undef = i_bit;
            2'b10:   instr_undef = (Instr[25:24] != 2'b10);
            default: instr_undef = 1'b1;
        endcase
        if (cond == 4'b1111) instr_undef = 1'b1;
    end

    // Condition evaluated against the architectural register, never the live ALU flags.
    always_comb begin
        logic fn, fz, fc, fv;
        {fn, fz, fc, fv} = flags_q;
        case (cond)
            4'b0000: cond_ok = fz;
            4'b0001: cond_ok = !fz;
            4'b0010: cond_ok = fc;
            4'b0011: cond_ok = !fc;
            4'b0100: cond_ok = fn;
            4'b0101: cond_ok = !fn;
            4'b0110: cond_ok = fv;
            4'b0111: cond_ok = !fv;
            4'b1000: cond_ok = fc && !fz;
            4'b1001: cond_ok = !fc || fz;
            4'b1010: cond_ok = (fn == fv);
            4'b1011: cond_ok = (fn != fv);
            4'b1100: cond_ok = !fz && (fn == fv);
            4'b1101: cond_ok = fz || (fn != fv);
            default: cond_ok = 1'b1;
        endcase
    end

    // State and flag registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH;
            flags_q <= RESET_FLAGS;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Next-state and next-flags
    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (instr_undef || !cond_ok) state_d = S_FETCH;
                else begin
                    case (op)
                        2'b00:   state_d = i_bit ? S_EXECI : S_EXECR;
                        2'b01:   state_d = S_MEMADR;
                        2'b10:   state_d = S_BRANCH;
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR:   state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR, S_EXECI: begin
                state_d = flag_only ? S_FETCH : S_ALUWB;
                if (s_bit) begin
                    flags_d[3:2] = {N, Z};
                    // Logical ops (AND/ORR/TST) keep C and V.
                    if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010)
                        flags_d[1:0] = {C, V};
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Moore outputs (write enables before reset gating)
    logic pcw_raw, memw_raw, irw_raw, regw_raw;
    logic [1:0] alu_dp;

    always_comb begin
        case (cmd)
            4'b0010, 4'b1010: alu_dp = 2'b01;
            4'b0000, 4'b1000: alu_dp = 2'b10;
            4'b1100:          alu_dp = 2'b11;
            default:          alu_dp = 2'b00;
        endcase
    end

    always_comb begin
        pcw_raw    = 1'b0;
        AdrSrc     = 1'b0;
        memw_raw   = 1'b0;
        irw_raw    = 1'b0;
        regw_raw   = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        Undef      = 1'b0;
        case (state_q)
            S_FETCH: begin
                irw_raw   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pcw_raw   = 1'b1;
            end
            S_DECODE: begin
                // PC+8 on the result bus so R15 reads see it.
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                Undef     = instr_undef;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = u_bit ? 2'b00 : 2'b01;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                regw_raw  = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                memw_raw = 1'b1;
            end
            S_EXECR: ALUControl = alu_dp;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dp;
            end
            S_ALUWB: regw_raw = 1'b1;
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcw_raw   = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are killed while reset is held; selects keep their FETCH values.
    assign PCWrite  = pcw_raw  & reset_n;
    assign IRWrite  = irw_raw  & reset_n;
    assign RegWrite = regw_raw & reset_n;
    assign MemWrite = memw_raw & reset_n;

    assign ImmSrc = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
    assign RegSrc = (op == 2'b10)            ? 2'b01 :
                    (op == 2'b01 && !l_bit)  ? 2'b10 : 2'b00;
    assign Flags  = flags_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : self-checking bench for multicycle_ctrl; per-cycle expected control words
//           are queued per instruction and popped at each negedge sample.
// Latency : n/a.  Backpr.: n/a.
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] Instr;
    logic        N, Z, C, V;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA, Undef;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags;

    always #5 clock = ~clock;

    multicycle_ctrl #(.RESET_FLAGS(4'b0000)) dut (
        .clock(clock), .reset_n(reset_n), .Instr(Instr),
        .N(N), .Z(Z), .C(C), .V(V),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .Undef(Undef), .Flags(Flags)
    );

    logic [16:0] got_ctl;
    assign got_ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
                      ALUSrcB, ALUControl, ImmSrc, RegSrc, Undef};

    typedef struct packed {
        logic [16:0] ctl;
        logic [3:0]  flg;
    } exp_t;

    exp_t       sb_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [1:0] cur_imm, cur_rsc;
    logic [3:0] ef;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] cw(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, input logic sa,
                                       input logic [1:0] sb, ac, input logic und);
        return {pcw, adr, mw, irw, rw, rs, sa, sb, ac, cur_imm, cur_rsc, und};
    endfunction

    task automatic push(input logic [16:0] c);
        exp_t e;
        e.ctl = c;
        e.flg = ef;
        sb_q.push_back(e);
    endtask

    task automatic p_fetch;             push(cw(1,0,0,1,0,2'b10,1,2'b10,2'b00,0)); endtask
    task automatic p_decode(input logic u); push(cw(0,0,0,0,0,2'b10,1,2'b10,2'b00,u)); endtask
    task automatic p_memadr(input logic [1:0] ac); push(cw(0,0,0,0,0,2'b00,0,2'b01,ac,0)); endtask
    task automatic p_memread;           push(cw(0,1,0,0,0,2'b00,0,2'b00,2'b00,0)); endtask
    task automatic p_memwb;             push(cw(0,0,0,0,1,2'b01,0,2'b00,2'b00,0)); endtask
    task automatic p_memwrite;          push(cw(0,1,1,0,0,2'b00,0,2'b00,2'b00,0)); endtask
    task automatic p_exec(input logic [1:0] sb, input logic [1:0] ac);
        push(cw(0,0,0,0,0,2'b00,0,sb,ac,0));
    endtask
    task automatic p_aluwb;             push(cw(0,0,0,0,1,2'b00,0,2'b00,2'b00,0)); endtask
    task automatic p_branch;            push(cw(1,0,0,0,0,2'b10,0,2'b01,2'b00,0)); endtask
    task automatic p_inreset;           push(cw(0,0,0,0,0,2'b10,1,2'b10,2'b00,0)); endtask

    task automatic sample(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s scoreboard empty got_ctl=%h", tag, got_ctl);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_ctl"}, {15'b0, got_ctl}, {15'b0, e.ctl});
            chk({tag, "_flags"}, {28'b0, Flags}, {28'b0, e.flg});
        end
    endtask

    task automatic cycles(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sample($sformatf("%s_c%0d", name, i));
            @(posedge clock);
            #1;
        end
    endtask

    task automatic set_instr(input logic [31:0] ins, input logic [1:0] imm,
                             input logic [1:0] rsc, input logic [3:0] alu);
        Instr   = ins;
        {N, Z, C, V} = alu;
        cur_imm = imm;
        cur_rsc = rsc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ef      = 4'b0000;
        reset_n = 1'b1;
        set_instr(32'hE0821003, 2'b00, 2'b00, 4'b1111);
        #1 reset_n = 1'b0;
        #2;
        p_inreset; sample("rst0");
        @(posedge clock); #1;
        p_inreset; sample("rst1");
        @(posedge clock); #1;
        reset_n = 1'b1;

        // ADD R1,R2,R3 (S=0: ALU flags must be ignored)
        p_fetch; p_decode(0); p_exec(2'b00, 2'b00); p_aluwb;
        cycles("add", 4);

        // LDR R0,[R1,#4]
        set_instr(32'hE5910004, 2'b01, 2'b00, 4'b0000);
        p_fetch; p_decode(0); p_memadr(2'b00); p_memread; p_memwb;
        cycles("ldr", 5);

        // STR R0,[R1,#-8]
        set_instr(32'hE5010008, 2'b01, 2'b10, 4'b0000);
        p_fetch; p_decode(0); p_memadr(2'b01); p_memwrite;
        cycles("str", 4);

        // SUBS R0,R0,#1 with ALU NZCV=0110
        set_instr(32'hE2500001, 2'b00, 2'b00, 4'b0110);
        p_fetch; p_decode(0); p_exec(2'b01, 2'b01);
        ef = 4'b0110;
        p_aluwb;
        cycles("subs", 4);

        // BEQ taken
        set_instr(32'h0A000002, 2'b10, 2'b01, 4'b0000);
        p_fetch; p_decode(0); p_branch;
        cycles("beq", 3);

        // BNE not taken
        set_instr(32'h1A000002, 2'b10, 2'b01, 4'b0000);
        p_fetch; p_decode(0);
        cycles("bne", 2);

        // ANDS R0,R0,R0 with ALU NZCV=1001: C,V hold -> 1010
        set_instr(32'hE0100000, 2'b00, 2'b00, 4'b1001);
        p_fetch; p_decode(0); p_exec(2'b00, 2'b10);
        ef = 4'b1010;
        p_aluwb;
        cycles("ands", 4);

        // ORR R0,R0,#1 (S=0)
        set_instr(32'hE3800001, 2'b00, 2'b00, 4'b0101);
        p_fetch; p_decode(0); p_exec(2'b01, 2'b11); p_aluwb;
        cycles("orr", 4);

        // ADDEQ with Z=0: condition false
        set_instr(32'h00821003, 2'b00, 2'b00, 4'b0000);
        p_fetch; p_decode(0);
        cycles("addeq", 2);

        // Undefined encodings: MEM with I=1, cond=1111, EOR
        set_instr(32'hE6000000, 2'b01, 2'b10, 4'b0000);
        p_fetch; p_decode(1);
        cycles("und_mem", 2);
        set_instr(32'hF0821003, 2'b00, 2'b00, 4'b0000);
        p_fetch; p_decode(1);
        cycles("und_cond", 2);
        set_instr(32'hE0200000, 2'b00, 2'b00, 4'b0000);
        p_fetch; p_decode(1);
        cycles("und_eor", 2);

        // CMP R0,#5 with ALU NZCV=0100
        set_instr(32'hE3500005, 2'b00, 2'b00, 4'b0100);
`ifdef CMP_TST_EN
        p_fetch; p_decode(0); p_exec(2'b01, 2'b01);
        ef = 4'b0100;
        cycles("cmp", 3);
`else
        p_fetch; p_decode(1);
        cycles("cmp", 2);
`endif

        // LDR abandoned by reset during MEMREAD
        set_instr(32'hE5910004, 2'b01, 2'b00, 4'b0000);
        p_fetch; p_decode(0); p_memadr(2'b00); p_memread;
        cycles("ldr_rst", 3);
        @(negedge clock);
        sample("ldr_rst_c3");
        #1 reset_n = 1'b0;
        #1;
        ef = 4'b0000;
        p_inreset; sample("midrst0");
        @(posedge clock); #1;
        p_inreset; sample("midrst1");
        reset_n = 1'b1;

        // First instruction after release: normal FETCH with IRWrite/PCWrite
        set_instr(32'hE0821003, 2'b00, 2'b00, 4'b0000);
        p_fetch; p_decode(0); p_exec(2'b00, 2'b00); p_aluwb;
        cycles("add2", 4);

        chk("sb_drain", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
